lift_car_model: RTL
===================

LIFT_CAR_MODEL -- requirements
Module: lift_car_model

Interface
REQ-001 Parameter N_FLOORS, default 12: number of floors served; floors are indexed 0..N_FLOORS-1.
REQ-002 Parameter TICKS_PER_FLOOR, default 8: clock cycles needed to travel one floor; legal values are 2 or more.
REQ-003 Parameter DOOR_TICKS, default 4: clock cycles for a full door open or close stroke; legal values are 1 or more.
REQ-004 Parameter START_FLOOR, default 0: floor the car occupies after reset.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 motion  input  1  controller's request to move the car.
REQ-008 direction  input  1  travel direction: 1 = up, 0 = down.
REQ-009 door_open  input  1  controller's request to open the door (level).
REQ-010 floor_sense  output  N_FLOORS  one-hot floor-alignment sensor; all zeros between floors.
REQ-011 cur_floor  output  $clog2(N_FLOORS)  last floor reached.
REQ-012 door_closed  output  1  door is fully closed.
REQ-013 door_full_open  output  1  door is fully open.
REQ-014 fault  output  1  sticky flag for a command violation.

Function
REQ-015 The car SHALL implement an FSM with states IDLE, MOVING, DOOR_OPENING, DOOR_OPEN and DOOR_CLOSING.
REQ-016 Position SHALL be held as floor index f plus sub-count c (0..TICKS_PER_FLOOR-1); when c==0, floor_sense SHALL equal one-hot(f), otherwise floor_sense SHALL be all zeros.
REQ-017 IDLE to MOVING: on motion=1, door_open=0 and the move is legal; the direction SHALL be latched that cycle and c advances from the next edge.
REQ-018 In MOVING, c SHALL increment each cycle; on the cycle after c==TICKS_PER_FLOOR-1, f SHALL step by ±1 (per the latched direction) and c SHALL return to 0, giving exactly TICKS_PER_FLOOR cycles per floor.
REQ-019 A direction change while c!=0 SHALL be ignored; the latched direction SHALL be re-sampled only when c==0.
REQ-020 When motion=0 at c==0, the car SHALL go to IDLE; motion deasserted mid-floor SHALL let the car complete travel to the next floor, then go to IDLE.
REQ-021 When c==0, motion=1 and an up request at f==N_FLOORS-1 or a down request at f==0 occurs, the car SHALL not move, SHALL set fault and SHALL stay in IDLE.
REQ-022 IDLE to DOOR_OPENING on door_open=1; door_open has priority over motion. If both are high, fault SHALL be set and no movement SHALL occur.
REQ-023 DOOR_OPENING SHALL last DOOR_TICKS cycles, then enter DOOR_OPEN; door_open=0 during opening SHALL go directly to DOOR_CLOSING with a full DOOR_TICKS count.
REQ-024 DOOR_OPEN SHALL be held while door_open=1; on door_open=0 the car SHALL enter DOOR_CLOSING.
REQ-025 DOOR_CLOSING SHALL last DOOR_TICKS cycles, then enter IDLE; door_open=1 during closing SHALL re-enter DOOR_OPENING with a full count (obstruction reopen).
REQ-026 motion=1 in any door state SHALL set fault and SHALL cause no movement.
REQ-027 door_closed SHALL be 1 only in IDLE and MOVING; door_full_open SHALL be 1 only in DOOR_OPEN.
REQ-028 fault SHALL stay set until reset.
REQ-029 cur_floor SHALL equal f at all times.

Reset
REQ-030 On reset low, asynchronously: state=IDLE, f=START_FLOOR, c=0, latched direction=up, door counter=0, fault=0.
REQ-031 After reset: floor_sense=one-hot(START_FLOOR), cur_floor=START_FLOOR, door_closed=1, door_full_open=0.
REQ-032 Reset asserted mid-travel or mid-stroke SHALL abandon the operation and return the car to START_FLOOR.

Structure
REQ-033 The FSM state enum and the direction encoding (DIR_UP=1, DIR_DOWN=0) SHALL live in the shared package lift_pkg.
REQ-034 The door stroke counter and its state sub-machine SHALL be one sub-module, lift_car_door_fsm; travel logic SHALL stay in the top module.

Verification
REQ-035 Reset, then motion=1, direction=1 for 3*8 cycles, then motion=0 -> floor_sense passes 0x001, 0x002, 0x004, 0x008, with 7 zero cycles between each; cur_floor=3.
REQ-036 At floor 2, pulse motion=1 for 1 cycle -> car travels 8 cycles, stops at floor 3, floor_sense=0x008.
REQ-037 At floor 0, motion=1, direction=0 -> no movement, fault=1 next cycle, floor_sense stays 0x001.
REQ-038 door_open=1 for 10 cycles, then 0 -> door_closed=0 for 4+6+4 cycles, door_full_open=1 for 6 cycles.
REQ-039 During DOOR_CLOSING (2 cycles in), door_open=1 -> DOOR_OPENING restarts with a full 4 cycles; fault=0.
REQ-040 Reset low during MOVING at c=5, floor 4 -> outputs match REQ-031 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lift_pkg
//  Description : Shared types and constants for the lift car model: the car
//                state enumeration, the direction encoding and a small helper
//                deciding whether a move request is physically possible.
//  Revision    : 1.0  initial release
// ============================================================================
package lift_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_MOVING       = 3'd1,
        ST_DOOR_OPENING = 3'd2,
        ST_DOOR_OPEN    = 3'd3,
        ST_DOOR_CLOSING = 3'd4
    } car_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A move is possible unless it would run off the top or bottom floor.
    function automatic logic move_legal(input logic dir,
                                        input logic at_top,
                                        input logic at_bottom);
        return (dir == DIR_UP) ? !at_top : !at_bottom;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_car_model_if.sv
`default_nettype none
// ============================================================================
//  Module      : lift_car_model_if
//  Description : Controller <-> car signal bundle. The controller (master)
//                issues motion/direction/door commands; the car (slave)
//                reports floor sensors, position, door status and fault.
//  Revision    : 1.0  initial release
// ============================================================================
interface lift_car_model_if #(
    parameter int N_FLOORS = 12
) ();
    localparam int FW = $clog2(N_FLOORS);

    logic                motion;
    logic                direction;
    logic                door_open;
    logic [N_FLOORS-1:0] floor_sense;
    logic [FW-1:0]       cur_floor;
    logic                door_closed;
    logic                door_full_open;
    logic                fault;

    modport master (
        output motion, direction, door_open,
        input  floor_sense, cur_floor, door_closed, door_full_open, fault
    );

    modport slave (
        input  motion, direction, door_open,
        output floor_sense, cur_floor, door_closed, door_full_open, fault
    );
endinterface
`default_nettype wire

// File: rtl/lift_car_door_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : lift_car_door_fsm
//  Description : Door stroke sub-machine. Tracks closed / opening / open /
//                closing with a down-counting stroke timer. A reversal in
//                mid-stroke always restarts the new stroke with a full count.
//  Revision    : 1.0  initial release
// ============================================================================
module lift_car_door_fsm
    import lift_pkg::*;
#(
    parameter int DOOR_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_open,
    input  logic       parked,
    output car_state_t door_state
);
    localparam int             DW       = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [DW-1:0]  CNT_FULL = DW'(DOOR_TICKS - 1);

    car_state_t    state;
    car_state_t    state_next;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_next;

    // Door state and stroke timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next door state; the counter holds the remaining cycles of the stroke.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (door_open && parked) begin
                    state_next = ST_DOOR_OPENING;
                    cnt_next   = CNT_FULL;
                end
            end
            ST_DOOR_OPENING: begin
                if (!door_open) begin
                    state_next = ST_DOOR_CLOSING;
                    cnt_next   = CNT_FULL;
                end else if (cnt == '0) begin
                    state_next = ST_DOOR_OPEN;
                end else begin
                    cnt_next = cnt - DW'(1);
                end
            end
            ST_DOOR_OPEN: begin
                if (!door_open) begin
                    state_next = ST_DOOR_CLOSING;
                    cnt_next   = CNT_FULL;
                end
            end
            ST_DOOR_CLOSING: begin
                if (door_open) begin
                    state_next = ST_DOOR_OPENING;
                    cnt_next   = CNT_FULL;
                end else if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - DW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign door_state = state;

endmodule
`default_nettype wire

// File: rtl/lift_car_model.sv
`default_nettype none
// ============================================================================
//  Module      : lift_car_model
//  Description : Behavioural lift car. Position is a floor index plus a
//                sub-floor tick count; the car travels one floor per
//                TICKS_PER_FLOOR cycles, checks commands only when aligned
//                with a floor, and flags illegal commands with a sticky fault.
//  Revision    : 1.0  initial release
// ============================================================================
module lift_car_model
    import lift_pkg::*;
#(
    parameter int N_FLOORS        = 12,
    parameter int TICKS_PER_FLOOR = 8,
    parameter int DOOR_TICKS      = 4,
    parameter int START_FLOOR     = 0
) (
    input  logic            clk,
    input  logic            reset,
    lift_car_model_if.slave bus
);
    localparam int            FW         = $clog2(N_FLOORS);
    localparam int            CW         = $clog2(TICKS_PER_FLOOR);
    localparam logic [FW-1:0] FLOOR_TOP  = FW'(N_FLOORS - 1);
    localparam logic [FW-1:0] FLOOR_HOME = FW'(START_FLOOR);
    localparam logic [CW-1:0] SUB_LAST   = CW'(TICKS_PER_FLOOR - 1);

    car_state_t          travel_state;
    car_state_t          travel_next;
    car_state_t          door_state;
    car_state_t          car_state;
    logic [FW-1:0]       floor_idx;
    logic [FW-1:0]       floor_next;
    logic [CW-1:0]       sub_cnt;
    logic [CW-1:0]       sub_next;
    logic                dir;
    logic                dir_next;
    logic                launch;
    logic                launch_next;
    logic                fault;
    logic                fault_next;
    logic                door_idle;
    logic                parked;
    logic                at_floor;
    logic                at_top;
    logic                at_bottom;
    logic                req_legal;
    logic [N_FLOORS-1:0] sense;

    assign door_idle = (door_state == ST_IDLE);
    assign parked    = (travel_state == ST_IDLE);
    assign at_floor  = (sub_cnt == '0);
    assign at_top    = (floor_idx == FLOOR_TOP);
    assign at_bottom = (floor_idx == '0);
    assign req_legal = move_legal(bus.direction, at_top, at_bottom);

    lift_car_door_fsm #(
        .DOOR_TICKS (DOOR_TICKS)
    ) u_door (
        .clk        (clk),
        .reset      (reset),
        .door_open  (bus.door_open),
        .parked     (parked),
        .door_state (door_state)
    );

    // Travel state, position, latched direction and sticky fault registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            travel_state <= ST_IDLE;
            floor_idx    <= FLOOR_HOME;
            sub_cnt      <= '0;
            dir          <= DIR_UP;
            launch       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            travel_state <= travel_next;
            floor_idx    <= floor_next;
            sub_cnt      <= sub_next;
            dir          <= dir_next;
            launch       <= launch_next;
            fault        <= fault_next;
        end
    end

    // Travel decisions. 'launch' marks the first cycle after departure so a
    // one-cycle motion pulse still commits the car to reaching the next floor.
    always_comb begin
        travel_next = travel_state;
        floor_next  = floor_idx;
        sub_next    = sub_cnt;
        dir_next    = dir;
        launch_next = 1'b0;
        fault_next  = fault;
        case (travel_state)
            ST_MOVING: begin
                if (launch || !at_floor) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_next   = '0;
                        floor_next = (dir == DIR_UP) ? floor_idx + FW'(1)
                                                     : floor_idx - FW'(1);
                    end else begin
                        sub_next = sub_cnt + CW'(1);
                    end
                end else if (!bus.motion || bus.door_open) begin
                    travel_next = ST_IDLE;
                    if (bus.motion) begin
                        fault_next = 1'b1;
                    end
                end else if (req_legal) begin
                    dir_next = bus.direction;
                    sub_next = CW'(1);
                end else begin
                    travel_next = ST_IDLE;
                    fault_next  = 1'b1;
                end
            end
            default: begin
                travel_next = ST_IDLE;
                if (bus.motion) begin
                    if (!door_idle || bus.door_open || !req_legal) begin
                        fault_next = 1'b1;
                    end else begin
                        travel_next = ST_MOVING;
                        dir_next    = bus.direction;
                        launch_next = 1'b1;
                    end
                end
            end
        endcase
    end

    generate
        for (genvar i = 0; i < N_FLOORS; i++) begin : g_floor_sense
            assign sense[i] = at_floor && (floor_idx == FW'(i));
        end
    endgenerate

    assign car_state          = (travel_state == ST_MOVING) ? ST_MOVING : door_state;
    assign bus.floor_sense    = sense;
    assign bus.cur_floor      = floor_idx;
    assign bus.door_closed    = (car_state == ST_IDLE) || (car_state == ST_MOVING);
    assign bus.door_full_open = (car_state == ST_DOOR_OPEN);
    assign bus.fault          = fault;

endmodule
`default_nettype wire
